// File: rtl/vector_alu_exec_unit.sv
// Sequential vector ALU wrapper: single-cycle lane ops, iterative lane-serial MUL,
// result held on a valid/ready response channel.
module vector_alu_exec_unit #(
  parameter int unsigned REG_WIDTH  = 256,
  parameter int unsigned ELEM_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic                 req_use_imm,
  input  logic [REG_WIDTH-1:0] req_a,
  input  logic [REG_WIDTH-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [REG_WIDTH-1:0] rsp_result,
  output logic                 rsp_zero,
  output logic                 busy
);
  localparam int unsigned NUM_LANES = REG_WIDTH / ELEM_WIDTH;
  localparam int unsigned LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_REPL = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [REG_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [REG_WIDTH-1:0]   result_d;
  logic                   zero_d;

  logic [REG_WIDTH-1:0]   b_eff, alu_vec, mul_vec;
  logic [ELEM_WIDTH-1:0]  a_l, b_l, r_l;
  logic [ELEM_WIDTH-1:0]  mul_a, mul_b, mul_p;

  // Single-cycle lane datapath on the live request (also forms the effective B for MUL capture)
  always_comb begin
    b_eff   = '0;
    alu_vec = '0;
    a_l     = '0;
    b_l     = '0;
    r_l     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      a_l = req_a[i*ELEM_WIDTH +: ELEM_WIDTH];
      b_l = req_use_imm ? req_b[ELEM_WIDTH-1:0] : req_b[i*ELEM_WIDTH +: ELEM_WIDTH];
      case (req_op)
        OP_ADD:  r_l = a_l + b_l;
        OP_SUB:  r_l = a_l - b_l;
        OP_REPL: r_l = req_b[ELEM_WIDTH-1:0];
        OP_SLL:  r_l = a_l << b_l[4:0];
        OP_SLT:  r_l = ($signed(a_l) < $signed(b_l)) ? ELEM_WIDTH'(1) : '0;
        default: r_l = '0;
      endcase
      b_eff[i*ELEM_WIDTH +: ELEM_WIDTH]   = b_l;
      alu_vec[i*ELEM_WIDTH +: ELEM_WIDTH] = r_l;
    end
  end

  // One shared lane multiplier; the selected lane is merged into the held result
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_q == LANE_W'(i)) begin
        mul_a = a_q[i*ELEM_WIDTH +: ELEM_WIDTH];
        mul_b = b_q[i*ELEM_WIDTH +: ELEM_WIDTH];
      end
    end
    mul_p   = mul_a * mul_b;
    mul_vec = rsp_result;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_q == LANE_W'(i)) mul_vec[i*ELEM_WIDTH +: ELEM_WIDTH] = mul_p;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = rsp_result;
    zero_d   = rsp_zero;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_op == OP_MUL) begin
            a_d     = req_a;
            b_d     = b_eff;
            lane_d  = '0;
            state_d = S_MUL;
          end else begin
            result_d = alu_vec;
            zero_d   = ~|alu_vec;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        result_d = mul_vec;
        lane_d   = lane_q + LANE_W'(1);
        if (lane_q == LANE_W'(NUM_LANES - 1)) begin
          zero_d  = ~|mul_vec;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lane_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_result <= result_d;
      rsp_zero   <= zero_d;
      req_ready  <= (state_d == S_IDLE);
      rsp_valid  <= (state_d == S_DONE);
      busy       <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_vector_alu_exec_unit.sv
// Scoreboard bench for vector_alu_exec_unit: directed cases plus randomized ops
// checked against a lane-wise arithmetic reference model.
module tb_vector_alu_exec_unit;
  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic         req_use_imm;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] rsp_result;
  logic         rsp_zero;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic hold = 1'b0;
  logic [256:0] sb_q[$];

  vector_alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_use_imm(req_use_imm), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: per-lane 32-bit result plus zero flag
  function automatic logic [256:0] model(input logic [2:0] op, input logic imm,
                                         input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    logic [31:0]  x, y, z;
    logic [63:0]  p;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      x = a[i*32 +: 32];
      y = imm ? b[31:0] : b[i*32 +: 32];
      case (op)
        3'd0: z = x + y;
        3'd1: z = x - y;
        3'd2: z = b[31:0];
        3'd3: begin p = {32'd0, x} * {32'd0, y}; z = p[31:0]; end
        3'd4: z = x << y[4:0];
        3'd5: z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        default: z = 32'd0;
      endcase
      r[i*32 +: 32] = z;
    end
    return {(r == '0), r};
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Response consumer: random backpressure unless held off
  always @(posedge clk) begin
    #1 rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: a handshake completes on the next rising edge
  always @(negedge clk) begin
    logic [256:0] e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 256'(rsp_valid), 256'(0));
      end else begin
        e = sb_q.pop_front();
        chk("rsp_result", rsp_result, e[255:0]);
        chk("rsp_zero", 256'(rsp_zero), 256'(e[256]));
      end
    end
  end

  // Drive one request, wait for acceptance, push expectation, check latency
  task automatic issue(input logic [2:0] op, input logic imm, input logic [255:0] a,
                       input logic [255:0] b, input logic given,
                       input logic [255:0] er, input logic ez);
    int n;
    bit ok;
    bit rdy_bad;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_use_imm = imm; req_a = a; req_b = b;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 256'(1), 256'(0));
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb_q.push_back(given ? {ez, er} : model(op, imm, a, b));
    #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_use_imm = 1'($urandom);
    req_a = rand_vec(); req_b = rand_vec();
    n = 0; rdy_bad = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      if (req_ready || !busy) rdy_bad = 1;
      @(negedge clk);
      n++;
    end
    chk("latency", 256'(n), (op == 3'd3) ? 256'(8) : 256'(0));
    chk("ready_low_while_busy", 256'(rdy_bad | req_ready), 256'(0));
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clk);
    chk("drain", 256'(sb_q.size()), 256'(0));
  endtask

  localparam logic [255:0] VA = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
  localparam logic [255:0] VB = 256'h00000009_00000007_00000006_00000005_00000004_00000003_00000002_00000001;

  initial begin
    logic [255:0] snap;
    logic         zsnap;
    logic [255:0] ra, rb;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_use_imm = 1'b0;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #22;
    chk("reset_req_ready", 256'(req_ready), 256'(1));
    chk("reset_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_result", rsp_result, 256'(0));
    chk("reset_zero", 256'(rsp_zero), 256'(0));
    @(negedge clk); rst_n = 1'b1;

    issue(3'd0, 1'b0, VA, VB, 1'b1,
          256'h0000000a_00000009_00000009_00000009_00000009_00000009_00000009_00000009, 1'b0);
    issue(3'd3, 1'b0, VA, VB, 1'b1,
          256'h00000009_0000000e_00000012_00000014_00000014_00000012_0000000e_00000008, 1'b0);
    issue(3'd5, 1'b0, VA, VB, 1'b1,
          256'h00000001_00000001_00000001_00000001_00000000_00000000_00000000_00000000, 1'b0);
    issue(3'd1, 1'b0, VA, VA, 1'b1, 256'(0), 1'b1);
    issue(3'd4, 1'b1, VA,
          256'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_00000003, 1'b1,
          256'h00000008_00000010_00000018_00000020_00000028_00000030_00000038_00000040, 1'b0);
    rb = rand_vec(); rb[31:0] = 32'hdeadbeef;
    issue(3'd2, 1'b0, rand_vec(), rb, 1'b1, {8{32'hdeadbeef}}, 1'b0);
    issue(3'd6, 1'b0, rand_vec(), rand_vec(), 1'b1, 256'(0), 1'b1);
    issue(3'd7, 1'b1, rand_vec(), rand_vec(), 1'b1, 256'(0), 1'b1);
    drain();

    // Backpressure: response held, new request pending but not accepted
    hold = 1'b1;
    issue(3'd0, 1'b0, VA, VB, 1'b0, '0, 1'b0);
    snap = rsp_result; zsnap = rsp_zero;
    fork
      begin
        bit bad;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (rsp_result !== snap || rsp_zero !== zsnap || req_ready || !rsp_valid) bad = 1;
        end
        chk("backpressure_stable", 256'(bad), 256'(0));
        chk("backpressure_not_accepted", 256'(sb_q.size()), 256'(1));
        hold = 1'b0;
      end
      begin
        #3;
        issue(3'd2, 1'b1, rand_vec(), rand_vec(), 1'b0, '0, 1'b0);
      end
    join
    drain();

    // Reset during MUL iteration aborts the op
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd3; req_use_imm = 1'b0; req_a = VA; req_b = VB;
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("abort_result", rsp_result, 256'(0));
    chk("abort_busy", 256'(busy), 256'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", 256'(req_ready), 256'(1));
    issue(3'd0, 1'b0, VA, VB, 1'b1,
          256'h0000000a_00000009_00000009_00000009_00000009_00000009_00000009_00000009, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      ra = rand_vec();
      rb = ($urandom_range(0, 4) == 0) ? ra : rand_vec();
      if ($urandom_range(0, 3) == 0) rb = rb & {8{32'h0000001f}};
      issue(op, 1'($urandom_range(0, 1)), ra, rb, 1'b0, '0, 1'b0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
